guess_entry_checker: RTL and testbench



---
 rtl/guess_entry_checker_pkg.sv | 28 ++
 rtl/guess_entry_checker.sv | 158 +++++++++++++++
 tb/tb_guess_entry_checker.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/guess_entry_checker_pkg.sv
// Shared constants, state encoding and letter helpers for the guess entry/check path.
// The alphabet selector uses the same LETTER_BLANK code.
package guess_entry_checker_pkg;

  localparam int unsigned NUM_LETTERS = 8;
  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned WORD_W      = NUM_LETTERS * LETTER_W;
  localparam int unsigned CURSOR_W    = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned ATT_W       = 4;

  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd27;
  localparam logic [LETTER_W-1:0] LETTER_MAX   = 5'd25;
  localparam logic [ATT_W-1:0]    ATT_MAX      = 4'd15;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    CHECK  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // Extract letter k from a packed word (letter k sits at [5k+4:5k]).
  function automatic logic [LETTER_W-1:0] word_letter(input logic [WORD_W-1:0] w,
                                                      input logic [IDX_W-1:0] k);
    return w[int'(k)*LETTER_W +: LETTER_W];
  endfunction

endpackage

// File: rtl/guess_entry_checker.sv
// Collects an 8-letter guess keypress by keypress, then compares it one letter per
// cycle against a latched target and holds the result until the next clear.
module guess_entry_checker
  import guess_entry_checker_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                letter_valid,
  input  logic                backspace,
  input  logic                submit,
  input  logic                clear,
  input  logic [WORD_W-1:0]   target_word,
  output logic [WORD_W-1:0]   guess_word,
  output logic [NUM_LETTERS-1:0] is_correct,
  output logic                mode,
  output logic [CURSOR_W-1:0] cursor,
  output logic                busy,
  output logic                all_correct,
  output logic [ATT_W-1:0]    attempts
);

  localparam logic [1:0] ST_ENTRY  = 2'(ENTRY);
  localparam logic [1:0] ST_CHECK  = 2'(CHECK);
  localparam logic [1:0] ST_RESULT = 2'(RESULT);

  localparam logic [CURSOR_W-1:0] CURSOR_FULL = CURSOR_W'(NUM_LETTERS);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_LETTERS - 1);

  logic [1:0]                 state_q, state_d;
  logic [LETTER_W-1:0]        slot_q [NUM_LETTERS];
  logic [LETTER_W-1:0]        slot_d [NUM_LETTERS];
  logic [CURSOR_W-1:0]        cursor_q, cursor_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WORD_W-1:0]          target_q, target_d;
  logic [NUM_LETTERS-1:0]     is_correct_q, is_correct_d;
  logic                       mode_q, mode_d;
  logic                       busy_q, busy_d;
  logic                       all_correct_q, all_correct_d;
  logic [ATT_W-1:0]           attempts_q, attempts_d;

  logic                       letter_ok_c;
  logic                       cmp_eq_c;

  assign letter_ok_c = (letter_in <= LETTER_MAX) && (cursor_q < CURSOR_FULL);
  assign cmp_eq_c    = (slot_q[idx_q] == word_letter(target_q, idx_q));

  // Next-state and datapath update; every command outside its legal state is dropped.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    cursor_d      = cursor_q;
    idx_d         = idx_q;
    target_d      = target_q;
    is_correct_d  = is_correct_q;
    mode_d        = mode_q;
    busy_d        = busy_q;
    all_correct_d = all_correct_q;
    attempts_d    = attempts_q;

    unique case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          for (int i = 0; i < NUM_LETTERS; i++) slot_d[i] = LETTER_BLANK;
          cursor_d = '0;
        end else if (submit) begin
          if (cursor_q == CURSOR_FULL) begin
            target_d     = target_word;
            is_correct_d = '0;
            idx_d        = '0;
            busy_d       = 1'b1;
            state_d      = ST_CHECK;
          end
        end else if (backspace) begin
          if (cursor_q != '0) begin
            slot_d[IDX_W'(cursor_q - 4'd1)] = LETTER_BLANK;
            cursor_d = cursor_q - 4'd1;
          end
        end else if (letter_valid && letter_ok_c) begin
          slot_d[IDX_W'(cursor_q)] = letter_in;
          cursor_d = cursor_q + 4'd1;
        end
      end

      ST_CHECK: begin
        if (clear) begin
          for (int i = 0; i < NUM_LETTERS; i++) slot_d[i] = LETTER_BLANK;
          cursor_d     = '0;
          is_correct_d = '0;
          busy_d       = 1'b0;
          state_d      = ST_ENTRY;
        end else begin
          is_correct_d[idx_q] = cmp_eq_c;
          idx_d = idx_q + 3'd1;
          // Last slot: the AND includes this cycle's compare so all_correct rises with mode.
          if (idx_q == IDX_LAST) begin
            all_correct_d = &is_correct_d;
            busy_d        = 1'b0;
            mode_d        = 1'b1;
            state_d       = ST_RESULT;
            if (attempts_q != ATT_MAX) attempts_d = attempts_q + 4'd1;
          end
        end
      end

      ST_RESULT: begin
        if (clear) begin
          for (int i = 0; i < NUM_LETTERS; i++) slot_d[i] = LETTER_BLANK;
          cursor_d      = '0;
          is_correct_d  = '0;
          mode_d        = 1'b0;
          all_correct_d = 1'b0;
          state_d       = ST_ENTRY;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ENTRY;
      for (int i = 0; i < NUM_LETTERS; i++) slot_q[i] <= LETTER_BLANK;
      cursor_q      <= '0;
      idx_q         <= '0;
      target_q      <= '0;
      is_correct_q  <= '0;
      mode_q        <= 1'b0;
      busy_q        <= 1'b0;
      all_correct_q <= 1'b0;
      attempts_q    <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      cursor_q      <= cursor_d;
      idx_q         <= idx_d;
      target_q      <= target_d;
      is_correct_q  <= is_correct_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      all_correct_q <= all_correct_d;
      attempts_q    <= attempts_d;
    end
  end

  for (genvar g = 0; g < NUM_LETTERS; g++) begin : g_pack
    assign guess_word[g*LETTER_W +: LETTER_W] = slot_q[g];
  end

  assign is_correct  = is_correct_q;
  assign mode        = mode_q;
  assign cursor      = cursor_q;
  assign busy        = busy_q;
  assign all_correct = all_correct_q;
  assign attempts    = attempts_q;

endmodule

// File: tb/tb_guess_entry_checker.sv
// Scoreboard bench: the driver updates a behavioural model each cycle and queues the
// expected outputs; an independent monitor compares the DUT after every clock edge.
module tb_guess_entry_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  letter_in = '0;
  logic        letter_valid = 1'b0, backspace = 1'b0, submit = 1'b0, clear = 1'b0;
  logic [39:0] target_word = '0;
  logic [39:0] guess_word;
  logic [7:0]  is_correct;
  logic        mode, busy, all_correct;
  logic [3:0]  cursor, attempts;

  guess_entry_checker dut (
    .clk(clk), .rst_n(rst_n), .letter_in(letter_in), .letter_valid(letter_valid),
    .backspace(backspace), .submit(submit), .clear(clear), .target_word(target_word),
    .guess_word(guess_word), .is_correct(is_correct), .mode(mode), .cursor(cursor),
    .busy(busy), .all_correct(all_correct), .attempts(attempts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] gw;
    logic [7:0]  ic;
    logic        md;
    logic [3:0]  cur;
    logic        bsy;
    logic        allc;
    logic [3:0]  att;
  } snap_t;

  snap_t sbq[$];
  int total = 0;
  int bad = 0;

  // Behavioural model: what the player has typed, and how far the check has progressed.
  localparam int PH_TYPING = 0, PH_COMPARING = 1, PH_SHOWING = 2;
  int          m_slot[8];
  int          m_count;
  int          m_phase;
  int          m_checked;
  logic [39:0] m_tgt;
  bit          m_match[8];
  int          m_att;

  function automatic int tgt_letter(logic [39:0] w, int k);
    return int'(w[k*5 +: 5]);
  endfunction

  task automatic model_blank();
    for (int i = 0; i < 8; i++) m_slot[i] = 27;
    m_count = 0;
  endtask

  task automatic model_reset();
    model_blank();
    m_phase = PH_TYPING; m_checked = 0; m_tgt = '0; m_att = 0;
    for (int i = 0; i < 8; i++) m_match[i] = 1'b0;
  endtask

  task automatic model_cmd(bit c, bit s, bit b, bit v, int l, logic [39:0] t);
    if (m_phase == PH_TYPING) begin
      if (c) model_blank();
      else if (s) begin
        if (m_count == 8) begin
          m_tgt = t; m_checked = 0; m_phase = PH_COMPARING;
          for (int i = 0; i < 8; i++) m_match[i] = 1'b0;
        end
      end else if (b) begin
        if (m_count > 0) begin m_count--; m_slot[m_count] = 27; end
      end else if (v && l <= 25 && m_count < 8) begin
        m_slot[m_count] = l; m_count++;
      end
    end else if (m_phase == PH_COMPARING) begin
      if (c) begin
        model_blank(); m_phase = PH_TYPING;
        for (int i = 0; i < 8; i++) m_match[i] = 1'b0;
      end else begin
        m_match[m_checked] = (m_slot[m_checked] == tgt_letter(m_tgt, m_checked));
        m_checked++;
        if (m_checked == 8) begin
          m_phase = PH_SHOWING;
          m_att = (m_att < 15) ? m_att + 1 : 15;
        end
      end
    end else if (c) begin
      model_blank(); m_phase = PH_TYPING;
      for (int i = 0; i < 8; i++) m_match[i] = 1'b0;
    end
  endtask

  function automatic snap_t model_snap();
    snap_t e;
    bit every = 1'b1;
    e.gw = '0; e.ic = '0;
    for (int i = 0; i < 8; i++) begin
      e.gw[i*5 +: 5] = 5'(m_slot[i]);
      e.ic[i] = m_match[i];
      every &= m_match[i];
    end
    e.md   = (m_phase == PH_SHOWING);
    e.bsy  = (m_phase == PH_COMPARING);
    e.allc = (m_phase == PH_SHOWING) && every;
    e.cur  = 4'(m_count);
    e.att  = 4'(m_att);
    return e;
  endfunction

  function automatic logic [39:0] model_word();
    logic [39:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*5 +: 5] = 5'(m_slot[i]);
    return w;
  endfunction

  // Drive one cycle of commands and queue what the DUT must show after the next edge.
  task automatic step(bit c, bit s, bit b, bit v, int l);
    @(negedge clk);
    rst_n = 1'b1;
    clear = c; submit = s; backspace = b; letter_valid = v; letter_in = 5'(l);
    model_cmd(c, s, b, v, l, target_word);
    sbq.push_back(model_snap());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, $urandom_range(0, 31));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear = 0; submit = 0; backspace = 0; letter_valid = 0;
    model_reset();
    sbq.push_back(model_snap());
  endtask

  task automatic type_word(int w[8]);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, w[i]);
  endtask

  task automatic chk(string name, logic [39:0] act, logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    snap_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("guess_word",  guess_word,         e.gw);
      chk("is_correct",  40'(is_correct),    40'(e.ic));
      chk("mode",        40'(mode),          40'(e.md));
      chk("cursor",      40'(cursor),        40'(e.cur));
      chk("busy",        40'(busy),          40'(e.bsy));
      chk("all_correct", 40'(all_correct),   40'(e.allc));
      chk("attempts",    40'(attempts),      40'(e.att));
    end
  end

  initial begin
    int hello[8] = '{7, 4, 11, 11, 14, 22, 14, 17};
    int rw[8];
    logic [39:0] w;

    do_reset();
    idle(2);

    // Entry, overflow, backspace and illegal code.
    type_word(hello);
    step(0, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 30);
    step(0, 0, 0, 1, 17);

    // Mismatch at slot 3, target changed mid-check.
    w = model_word();
    w[15 +: 5] = 5'd0;
    target_word = w;
    step(0, 1, 0, 0, 0);
    idle(3);
    target_word = model_word();
    idle(7);
    step(1, 0, 0, 0, 0);

    // Exact match, then a short-word submit that must be ignored.
    type_word(hello);
    target_word = model_word();
    step(0, 1, 0, 0, 0);
    idle(10);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, hello[i]);
    step(0, 1, 0, 0, 0);
    idle(2);
    for (int i = 5; i < 8; i++) step(0, 0, 0, 1, hello[i]);

    // clear wins over submit; then abort a running check at T+3.
    step(1, 1, 0, 0, 0);
    idle(2);
    type_word(hello);
    step(0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0);
    idle(2);

    // Saturation of the attempt counter.
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 8; i++) rw[i] = $urandom_range(0, 3);
      type_word(rw);
      target_word = {8{5'($urandom_range(0, 3))}};
      step(0, 1, 0, 0, 0);
      idle(9);
      step(1, 0, 0, 0, 0);
    end

    // Reset in the middle of a check.
    type_word(hello);
    step(0, 1, 0, 0, 0);
    idle(3);
    do_reset();
    idle(2);

    // Random command mix over a small alphabet so matches occur.
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) begin
        for (int i = 0; i < 8; i++) w[i*5 +: 5] = 5'($urandom_range(0, 3));
        target_word = w;
      end
      if (n % 97 == 0) target_word = model_word();
      step(($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 7) == 0,
           ($urandom % 2) == 0,
           (($urandom % 10) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 3));
    end
    idle(1);

    @(posedge clk);
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
